// File: rtl/exe_input_stage.sv
// ID/EXE pipeline register with MEM/WB operand forwarding, NZCV status register
// and branch target generation for the EXE stage of the 5-stage ARM core.
module exe_input_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             fwd_en,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] id_val_rn,
  input  logic [WIDTH-1:0] id_val2,
  input  logic [3:0]       id_exe_cmd,
  input  logic             id_mem_r,
  input  logic             id_mem_w,
  input  logic             id_wb_en,
  input  logic             id_s,
  input  logic             id_b,
  input  logic [23:0]      id_imm24,
  input  logic [RADDR-1:0] id_dest,
  input  logic [RADDR-1:0] id_src1,
  input  logic [RADDR-1:0] id_src2,
  input  logic             id_fwd2,
  input  logic             mem_wb_en,
  input  logic [RADDR-1:0] mem_dest,
  input  logic [WIDTH-1:0] mem_alu_res,
  input  logic             wb_wb_en,
  input  logic [RADDR-1:0] wb_dest,
  input  logic [WIDTH-1:0] wb_value,
  input  logic [3:0]       alu_status,
  output logic [WIDTH-1:0] val1,
  output logic [WIDTH-1:0] val2,
  output logic [3:0]       exe_cmd,
  output logic             carry_in,
  output logic             ex_mem_r,
  output logic             ex_mem_w,
  output logic             ex_wb_en,
  output logic [RADDR-1:0] ex_dest,
  output logic [WIDTH-1:0] ex_pc,
  output logic [WIDTH-1:0] ex_val_rm,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_addr,
  output logic [3:0]       status_reg
);

  logic             valid_q;
  logic [WIDTH-1:0] val_rn_q;
  logic [WIDTH-1:0] val2_q;
  logic             mem_r_q;
  logic             mem_w_q;
  logic             wb_en_q;
  logic             s_q;
  logic             b_q;
  logic [23:0]      imm24_q;
  logic [RADDR-1:0] src1_q;
  logic [RADDR-1:0] src2_q;
  logic             fwd2_q;
  logic             fwd_on;
  logic [WIDTH-1:0] branch_off;

  // Flags belong to the instruction already in EXE, so they update even when
  // the incoming instruction is being flushed on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      val_rn_q   <= '0;
      val2_q     <= '0;
      exe_cmd    <= '0;
      mem_r_q    <= 1'b0;
      mem_w_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      s_q        <= 1'b0;
      b_q        <= 1'b0;
      imm24_q    <= '0;
      ex_dest    <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      fwd2_q     <= 1'b0;
      ex_pc      <= '0;
      status_reg <= 4'b0000;
    end else if (!freeze) begin
      if (valid_q && s_q) begin
        status_reg <= alu_status;
      end
      if (flush) begin
        valid_q  <= 1'b0;
        val_rn_q <= '0;
        val2_q   <= '0;
        exe_cmd  <= '0;
        mem_r_q  <= 1'b0;
        mem_w_q  <= 1'b0;
        wb_en_q  <= 1'b0;
        s_q      <= 1'b0;
        b_q      <= 1'b0;
        imm24_q  <= '0;
        ex_dest  <= '0;
        src1_q   <= '0;
        src2_q   <= '0;
        fwd2_q   <= 1'b0;
        ex_pc    <= '0;
      end else begin
        valid_q  <= id_valid;
        val_rn_q <= id_val_rn;
        val2_q   <= id_val2;
        exe_cmd  <= id_exe_cmd;
        mem_r_q  <= id_mem_r;
        mem_w_q  <= id_mem_w;
        wb_en_q  <= id_wb_en;
        s_q      <= id_s;
        b_q      <= id_b;
        imm24_q  <= id_imm24;
        ex_dest  <= id_dest;
        src1_q   <= id_src1;
        src2_q   <= id_src2;
        fwd2_q   <= id_fwd2;
        ex_pc    <= id_pc;
      end
    end
  end

  assign fwd_on = fwd_en & valid_q;

  // MEM is the younger producer, so it takes precedence over WB.
  always_comb begin
    val1 = val_rn_q;
    if (fwd_on) begin
      if (mem_wb_en && (mem_dest == src1_q)) begin
        val1 = mem_alu_res;
      end else if (wb_wb_en && (wb_dest == src1_q)) begin
        val1 = wb_value;
      end
    end
    val2 = val2_q;
    if (fwd_on && fwd2_q) begin
      if (mem_wb_en && (mem_dest == src2_q)) begin
        val2 = mem_alu_res;
      end else if (wb_wb_en && (wb_dest == src2_q)) begin
        val2 = wb_value;
      end
    end
  end

  assign ex_val_rm    = val2;
  assign carry_in     = status_reg[1];
  assign ex_mem_r     = mem_r_q & valid_q;
  assign ex_mem_w     = mem_w_q & valid_q;
  assign ex_wb_en     = wb_en_q & valid_q;
  assign branch_taken = b_q & valid_q;
  assign branch_off   = {{(WIDTH-26){imm24_q[23]}}, imm24_q, 2'b00};
  assign branch_addr  = ex_pc + branch_off;

endmodule

// File: doc/exe_input_stage.md
Name: exe_input_stage

Overview:
- ID/EXE pipeline register and operand-select front end of the EXE stage in the 5-stage ARM core.
- Captures decoded instructions from ID and applies MEM/WB forwarding to produce val1, val2, EXE_CMD and carryIn for the ALU.
- Holds the architectural {N,Z,C,V} status register, loaded from ALU status when the S bit is set.
- Computes the branch target and the taken flag.

Parameters:
- WIDTH, 32, datapath width.
- RADDR, 4, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- freeze  in  1  stall; hold all state.
- flush  in  1  replace the captured instruction with a bubble.
- fwd_en  in  1  global forwarding enable.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  WIDTH  PC+4 of the instruction.
- id_val_rn  in  WIDTH  Rn read value.
- id_val2  in  WIDTH  shifted/immediate operand 2.
- id_exe_cmd  in  4  ALU command.
- id_mem_r, id_mem_w, id_wb_en, id_s, id_b  in  1 each  control bits.
- id_imm24  in  24  branch offset.
- id_dest, id_src1, id_src2  in  RADDR each  register indices.
- id_fwd2  in  1  val2 is an unshifted register operand (forwardable).
- mem_wb_en  in  1  MEM-stage writeback enable.
- mem_dest  in  RADDR  MEM-stage destination index.
- mem_alu_res  in  WIDTH  MEM-stage ALU result.
- wb_wb_en  in  1  WB-stage writeback enable.
- wb_dest  in  RADDR  WB-stage destination index.
- wb_value  in  WIDTH  WB-stage writeback value.
- alu_status  in  4  {N,Z,C,V} from the ALU this cycle.
- val1, val2  out  WIDTH  ALU operands.
- exe_cmd  out  4  ALU command.
- carry_in  out  1  = status_reg[1] (C).
- ex_mem_r, ex_mem_w, ex_wb_en  out  1 each  control bits passed downstream (gated by valid).
- ex_dest  out  RADDR  destination index passed downstream.
- ex_pc  out  WIDTH  registered PC+4.
- ex_val_rm  out  WIDTH  forwarded val2 (store data path).
- branch_taken  out  1  = ex_valid & ex_b.
- branch_addr  out  WIDTH  = ex_pc + (sign_extend(imm24) << 2), modulo 2^WIDTH.
- status_reg  out  4  architectural flags to condition check in ID.

Behaviour:
- Priority at each rising edge: rst > freeze > flush > load.
- Reset values:
  - All registered fields 0; ex_valid=0; status_reg=4'b0000.
  - All outputs therefore 0, except exe_cmd=0 (ALU default: result 0).
- Load: all id_* fields captured; ex_valid=id_valid. Latency 1 cycle ID->ALU inputs.
- Freeze: every register holds, including status_reg.
  - Flush asserted while frozen is ignored that cycle. Branch source is held, so flush recurs after unfreeze.
- Flush (not frozen): ex_valid=0; control bits (mem_r, mem_w, wb_en, s, b) and exe_cmd cleared. Data fields are don't-care and cleared to 0.
- Downstream controls ex_mem_r, ex_mem_w, ex_wb_en and branch_taken are ANDed with ex_valid.
- Forwarding is combinational on registered src indices, active only when fwd_en & ex_valid.
  - val1: if mem_wb_en & mem_dest==ex_src1 -> mem_alu_res; elif wb_wb_en & wb_dest==ex_src1 -> wb_value; else registered val_rn. MEM beats WB.
  - val2/ex_val_rm: same selection on ex_src2, applied only when ex_fwd2=1; else registered val2.
  - fwd_en=0: registered values pass unmodified.
- Status register:
  - On edge, if !rst & !freeze & ex_valid & ex_s, status_reg <= alu_status.
  - Otherwise hold. A flushed instruction never updates flags.
- carry_in reflects status_reg as registered. Back-to-back S instructions see the previous instruction's C one cycle later, i.e. at that instruction's own EXE.
- Flush and status update on the same edge: the update belongs to the instruction currently in EXE and is applied; the flush affects the incoming one.
- branch_addr wraps modulo 2^WIDTH; negative imm24 (bit23=1) sign-extends.
- Reset mid-freeze: reset wins; all cleared.

Test Plan:
1. Reset: assert rst two edges with id_valid=1 -> all outputs 0, status_reg=0, branch_taken=0.
2. Forward priority:
   - Setup: load src1=3, val_rn=5; mem_wb_en=1, mem_dest=3, mem_alu_res=0xAA; wb_wb_en=1, wb_dest=3, wb_value=0xBB.
   - Expect val1=0xAA; drop mem_wb_en -> 0xBB; fwd_en=0 -> 5.
   - With id_fwd2=0 and src2=3, val2 stays id_val2=0x10.
3. Status: S instruction with alu_status=4'b0110 -> next edge status_reg=0110, carry_in=1; following non-S instruction with alu_status=1001 -> status_reg stays 0110.
4. Freeze/flush:
   - Load instruction A (wb_en=1), then freeze=1 with flush=1 for 3 cycles -> outputs hold A, status unchanged.
   - Release freeze with flush=1 -> ex_valid=0, ex_wb_en=0.
5. Branch: id_b=1, id_pc=0x100, imm24=0xFFFFFE -> branch_taken=1, branch_addr=0xF8; imm24=0x000004 -> 0x110; flushed branch -> branch_taken=0.
6. Flag-through-flush: S instruction in EXE with alu_status=1000 while flush=1 -> status_reg=1000; the bubble behind it causes no further update.
